// File: rtl/game_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | game_pkg: shared encodings, state enum and hand helpers for the game  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package game_pkg;

  typedef enum logic [1:0] {
    ST_MORA  = 2'd0,
    ST_POINT = 2'd1,
    ST_SHOW  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [2:0] c_flag_blank     = 3'b000;
  localparam logic [2:0] c_flag_up        = 3'b100;
  localparam logic [2:0] c_flag_down      = 3'b101;
  localparam logic [2:0] c_flag_left      = 3'b110;
  localparam logic [2:0] c_flag_right     = 3'b111;
  localparam logic [2:0] c_flag_left_win  = 3'b010;
  localparam logic [2:0] c_flag_right_win = 3'b001;

  localparam logic [2:0] c_step_mora  = 3'b100;
  localparam logic [2:0] c_step_point = 3'b010;
  localparam logic [2:0] c_step_over  = 3'b001;

  localparam logic [2:0] c_hand_rock     = 3'b100;
  localparam logic [2:0] c_hand_scissors = 3'b010;
  localparam logic [2:0] c_hand_paper    = 3'b001;

  localparam logic [3:0] c_dir_up    = 4'b1000;
  localparam logic [3:0] c_dir_down  = 4'b0100;
  localparam logic [3:0] c_dir_left  = 4'b0010;
  localparam logic [3:0] c_dir_right = 4'b0001;
  localparam logic [3:0] c_dir_none  = 4'b0000;

  localparam logic [1:0] c_mora_none  = 2'b00;
  localparam logic [1:0] c_mora_left  = 2'b10;
  localparam logic [1:0] c_mora_right = 2'b01;

  // Only legal one-hot pairs can win, so a true result implies both hands valid.
  function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
    return ((a == c_hand_rock)     && (b == c_hand_scissors)) ||
           ((a == c_hand_scissors) && (b == c_hand_paper))    ||
           ((a == c_hand_paper)    && (b == c_hand_rock));
  endfunction

  function automatic logic [2:0] arrow_code(input logic [3:0] dir);
    logic [2:0] code;
    code = c_flag_blank;
    case (dir)
      c_dir_up:    code = c_flag_up;
      c_dir_down:  code = c_flag_down;
      c_dir_left:  code = c_flag_left;
      c_dir_right: code = c_flag_right;
      default:     code = c_flag_blank;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mora_judge.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mora_judge: combinational hand comparison, result code + valid flag   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mora_judge
  import game_pkg::*;
(
  input  logic [2:0] left_hand,
  input  logic [2:0] right_hand,
  output logic [1:0] result,
  output logic       valid
);

  always_comb begin
    result = c_mora_none;
    if (beats(left_hand, right_hand)) begin
      result = c_mora_left;
    end else if (beats(right_hand, left_hand)) begin
      result = c_mora_right;
    end
  end

  assign valid = |result;

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | round_sequencer: tick-paced round FSM (MORA/POINT/SHOW/OVER), scores  |
// | Option macro: ROUND_SEQUENCER_AUTO_RESTART_EN (restart after OVER)    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module round_sequencer
  import game_pkg::*;
#(
  parameter int POINT_TICKS = 3,
  parameter int SHOW_TICKS  = 2,
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_W     = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TICK,
  input  logic [2:0]         Left_mora,
  input  logic [2:0]         Right_mora,
  input  logic [3:0]         Left_direct,
  input  logic [3:0]         Right_direct,
  output logic [SCORE_W-1:0] Left_score,
  output logic [SCORE_W-1:0] Right_score,
  output logic [3:0]         rnd,
  output logic [2:0]         flag,
  output logic [2:0]         step,
  output logic [1:0]         mora_result,
  output logic               round_done
);

  localparam int c_timer_max = (POINT_TICKS > SHOW_TICKS) ? POINT_TICKS : SHOW_TICKS;
  localparam int c_timer_w   = $clog2(c_timer_max + 1);

  state_t               r_state, w_state_nxt;
  logic [c_timer_w-1:0] r_timer, w_timer_nxt, w_timer_inc;
  logic [SCORE_W-1:0]   r_left_score, w_left_score_nxt;
  logic [SCORE_W-1:0]   r_right_score, w_right_score_nxt;
  logic [3:0]           r_rnd, w_rnd_nxt;
  logic [2:0]           r_flag, w_flag_nxt;
  logic [2:0]           r_step, w_step_nxt;
  logic [1:0]           r_mora_result, w_mora_result_nxt;
  logic                 r_round_done, w_round_done_nxt;

  logic [1:0]           w_judge_result;
  logic                 w_judge_valid;
  logic [3:0]           w_loser_direct;

  mora_judge u_mora_judge (
    .left_hand  (Left_mora),
    .right_hand (Right_mora),
    .result     (w_judge_result),
    .valid      (w_judge_valid)
  );

  assign w_timer_inc    = r_timer + 1'b1;
  // The hand winner's own look input is irrelevant; only the loser answers.
  assign w_loser_direct = (r_mora_result == c_mora_left) ? Right_direct : Left_direct;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ST_MORA;
      r_timer       <= '0;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_rnd         <= c_dir_right;
      r_flag        <= c_flag_blank;
      r_step        <= c_step_mora;
      r_mora_result <= c_mora_none;
      r_round_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_left_score  <= w_left_score_nxt;
      r_right_score <= w_right_score_nxt;
      r_rnd         <= w_rnd_nxt;
      r_flag        <= w_flag_nxt;
      r_step        <= w_step_nxt;
      r_mora_result <= w_mora_result_nxt;
      r_round_done  <= w_round_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_timer_nxt       = r_timer;
    w_left_score_nxt  = r_left_score;
    w_right_score_nxt = r_right_score;
    w_flag_nxt        = r_flag;
    w_step_nxt        = r_step;
    w_mora_result_nxt = r_mora_result;
    w_round_done_nxt  = 1'b0;
    // Free-running rotation makes the pointing direction unpredictable to players.
    w_rnd_nxt         = (r_state == ST_MORA) ? {r_rnd[2:0], r_rnd[3]} : r_rnd;

    if (TICK) begin
      case (r_state)
        ST_MORA: begin
          if (w_judge_valid) begin
            w_mora_result_nxt = w_judge_result;
            w_timer_nxt       = '0;
            w_step_nxt        = c_step_point;
            w_state_nxt       = ST_POINT;
          end else begin
            w_mora_result_nxt = c_mora_none;
          end
        end

        ST_POINT: begin
          if (w_loser_direct == r_rnd) begin
            if (r_mora_result == c_mora_left) begin
              w_left_score_nxt = r_left_score + 1'b1;
            end else begin
              w_right_score_nxt = r_right_score + 1'b1;
            end
            w_flag_nxt  = arrow_code(r_rnd);
            w_timer_nxt = '0;
            w_step_nxt  = c_step_mora;
            w_state_nxt = ST_SHOW;
          end else if (w_loser_direct != c_dir_none) begin
            w_flag_nxt  = c_flag_blank;
            w_timer_nxt = '0;
            w_step_nxt  = c_step_mora;
            w_state_nxt = ST_SHOW;
          end else if (w_timer_inc == c_timer_w'(POINT_TICKS)) begin
            w_flag_nxt  = c_flag_blank;
            w_timer_nxt = '0;
            w_step_nxt  = c_step_mora;
            w_state_nxt = ST_SHOW;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end

        ST_SHOW: begin
          if (w_timer_inc == c_timer_w'(SHOW_TICKS)) begin
            w_timer_nxt       = '0;
            w_round_done_nxt  = 1'b1;
            w_mora_result_nxt = c_mora_none;
            if (r_left_score == SCORE_W'(WIN_SCORE)) begin
              w_flag_nxt  = c_flag_left_win;
              w_step_nxt  = c_step_over;
              w_state_nxt = ST_OVER;
            end else if (r_right_score == SCORE_W'(WIN_SCORE)) begin
              w_flag_nxt  = c_flag_right_win;
              w_step_nxt  = c_step_over;
              w_state_nxt = ST_OVER;
            end else begin
              w_flag_nxt  = c_flag_blank;
              w_step_nxt  = c_step_mora;
              w_state_nxt = ST_MORA;
            end
          end else begin
            w_timer_nxt = w_timer_inc;
          end
        end

        ST_OVER: begin
`ifdef ROUND_SEQUENCER_AUTO_RESTART_EN
          if (w_timer_inc == c_timer_w'(SHOW_TICKS)) begin
            w_timer_nxt       = '0;
            w_left_score_nxt  = '0;
            w_right_score_nxt = '0;
            w_flag_nxt        = c_flag_blank;
            w_step_nxt        = c_step_mora;
            w_round_done_nxt  = 1'b1;
            w_state_nxt       = ST_MORA;
          end else begin
            w_timer_nxt = w_timer_inc;
          end
`else
          w_state_nxt = ST_OVER;
`endif
        end

        default: w_state_nxt = ST_MORA;
      endcase
    end
  end

  assign Left_score  = r_left_score;
  assign Right_score = r_right_score;
  assign rnd         = r_rnd;
  assign flag        = r_flag;
  assign step        = r_step;
  assign mora_result = r_mora_result;
  assign round_done  = r_round_done;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_round_sequencer: directed game rounds checked against a rule model |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_round_sequencer;

  localparam int P_POINT = 2;
  localparam int P_SHOW  = 1;
  localparam int P_WIN   = 2;
  localparam int P_SW    = 3;

  logic            CLK = 1'b0;
  logic            RST;
  logic            TICK;
  logic [2:0]      Left_mora, Right_mora;
  logic [3:0]      Left_direct, Right_direct;
  logic [P_SW-1:0] Left_score, Right_score;
  logic [3:0]      rnd;
  logic [2:0]      flag, step;
  logic [1:0]      mora_result;
  logic            round_done;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  round_sequencer #(
    .POINT_TICKS (P_POINT),
    .SHOW_TICKS  (P_SHOW),
    .WIN_SCORE   (P_WIN),
    .SCORE_W     (P_SW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .TICK         (TICK),
    .Left_mora    (Left_mora),
    .Right_mora   (Right_mora),
    .Left_direct  (Left_direct),
    .Right_direct (Right_direct),
    .Left_score   (Left_score),
    .Right_score  (Right_score),
    .rnd          (rnd),
    .flag         (flag),
    .step         (step),
    .mora_result  (mora_result),
    .round_done   (round_done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- rule model ----------------
  // phase: 0 hand, 1 pointing, 2 result shown, 3 game over
  function automatic logic [2:0] prey(input logic [2:0] h);
    case (h)
      3'b100:  return 3'b010;
      3'b010:  return 3'b001;
      3'b001:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int hand_winner(input logic [2:0] l, input logic [2:0] r);
    if (prey(l) != 3'b000 && prey(l) == r) return 1;
    if (prey(r) != 3'b000 && prey(r) == l) return 2;
    return 0;
  endfunction

  function automatic logic [2:0] arrow(input logic [3:0] d);
    case (d)
      4'b1000: return 3'b100;
      4'b0100: return 3'b101;
      4'b0010: return 3'b110;
      4'b0001: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  int              m_phase, m_wait;
  logic [P_SW-1:0] m_ls, m_rs;
  logic [3:0]      m_rnd;
  logic [2:0]      m_flag, m_step;
  logic [1:0]      m_mr;
  logic            m_done;

  always @(posedge CLK or posedge RST) begin : model
    int ph, wt, w;
    logic [P_SW-1:0] ls, rs;
    logic [2:0] fl, st;
    logic [1:0] mr;
    logic [3:0] ans, rn;
    logic dn;
    if (RST) begin
      m_phase <= 0; m_wait <= 0; m_ls <= '0; m_rs <= '0;
      m_rnd <= 4'b0001; m_flag <= 3'b000; m_step <= 3'b100;
      m_mr <= 2'b00; m_done <= 1'b0;
    end else begin
      ph = m_phase; wt = m_wait; ls = m_ls; rs = m_rs;
      fl = m_flag; st = m_step; mr = m_mr; dn = 1'b0;
      rn = (m_phase == 0) ? ((m_rnd == 4'b1000) ? 4'b0001 : (m_rnd << 1)) : m_rnd;
      if (TICK) begin
        if (m_phase == 0) begin
          w = hand_winner(Left_mora, Right_mora);
          if (w == 0) mr = 2'b00;
          else begin
            mr = (w == 1) ? 2'b10 : 2'b01;
            wt = 0; ph = 1; st = 3'b010;
          end
        end else if (m_phase == 1) begin
          ans = (m_mr == 2'b10) ? Right_direct : Left_direct;
          if (ans == m_rnd) begin
            if (m_mr == 2'b10) ls = m_ls + 1; else rs = m_rs + 1;
            fl = arrow(m_rnd); ph = 2; st = 3'b100; wt = 0;
          end else if (ans != 4'b0000) begin
            fl = 3'b000; ph = 2; st = 3'b100; wt = 0;
          end else begin
            wt = m_wait + 1;
            if (wt == P_POINT) begin fl = 3'b000; ph = 2; st = 3'b100; wt = 0; end
          end
        end else if (m_phase == 2) begin
          wt = m_wait + 1;
          if (wt == P_SHOW) begin
            wt = 0; dn = 1'b1; mr = 2'b00;
            if (m_ls == P_WIN)      begin fl = 3'b010; st = 3'b001; ph = 3; end
            else if (m_rs == P_WIN) begin fl = 3'b001; st = 3'b001; ph = 3; end
            else                    begin fl = 3'b000; st = 3'b100; ph = 0; end
          end
        end else begin
`ifdef ROUND_SEQUENCER_AUTO_RESTART_EN
          wt = m_wait + 1;
          if (wt == P_SHOW) begin
            wt = 0; ls = '0; rs = '0; fl = 3'b000; st = 3'b100; ph = 0; dn = 1'b1;
          end
`endif
        end
      end
      m_phase <= ph; m_wait <= wt; m_ls <= ls; m_rs <= rs; m_rnd <= rn;
      m_flag <= fl; m_step <= st; m_mr <= mr; m_done <= dn;
    end
  end

  always @(negedge CLK) begin
    if (!RST && cmp_en) begin
      check("cmp_left_score",  8'(Left_score),  8'(m_ls));
      check("cmp_right_score", 8'(Right_score), 8'(m_rs));
      check("cmp_rnd",         8'(rnd),         8'(m_rnd));
      check("cmp_flag",        8'(flag),        8'(m_flag));
      check("cmp_step",        8'(step),        8'(m_step));
      check("cmp_mora_result", 8'(mora_result), 8'(m_mr));
      check("cmp_round_done",  8'(round_done),  8'(m_done));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_tick();
    TICK = 1'b1;
    @(negedge CLK);
    TICK = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic hands(input logic [2:0] l, input logic [2:0] r);
    Left_mora = l; Right_mora = r;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rnd"},   8'(rnd),         8'h1);
    check({tag, "_flag"},  8'(flag),        8'h0);
    check({tag, "_step"},  8'(step),        8'h4);
    check({tag, "_mr"},    8'(mora_result), 8'h0);
    check({tag, "_done"},  8'(round_done),  8'h0);
    check({tag, "_ls"},    8'(Left_score),  8'h0);
    check({tag, "_rs"},    8'(Right_score), 8'h0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; TICK = 1'b0;
    Left_mora = '0; Right_mora = '0; Left_direct = '0; Right_direct = '0;
    idle(2);
    check_reset_vals("reset");
    RST = 1'b0;
    cmp_en = 1'b1;
    idle(3);

    // 1: left wins hand, right looks the pointed way
    hands(3'b100, 3'b010);
    do_tick();
    check("t1_mr", 8'(mora_result), 8'h2);
    check("t1_step", 8'(step), 8'h2);
    hands(3'b000, 3'b000);
    idle(2);
    Right_direct = m_rnd;
    do_tick();
    check("t1_ls", 8'(Left_score), 8'h1);
    check("t1_flag_arrow", 8'(flag[2]), 8'h1);
    check("t1_flag_code", 8'(flag), 8'(arrow(m_rnd)));
    check("t1_step_show", 8'(step), 8'h4);
    Right_direct = '0;
    do_tick();
    check("t1_done", 8'(round_done), 8'h1);
    check("t1_flag_clr", 8'(flag), 8'h0);
    idle(1);
    check("t1_done_once", 8'(round_done), 8'h0);

    // 2: tie held for 5 ticks
    hands(3'b010, 3'b010);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      check("t2_mr", 8'(mora_result), 8'h0);
      check("t2_step", 8'(step), 8'h4);
      idle(1);
    end
    check("t2_ls", 8'(Left_score), 8'h1);
    // zero and multi-hot hands are never valid
    hands(3'b000, 3'b100); do_tick(); check("t2_zero", 8'(mora_result), 8'h0);
    hands(3'b110, 3'b001); do_tick(); check("t2_multi", 8'(mora_result), 8'h0);

    // 3: right wins hand, left never answers -> timeout
    hands(3'b010, 3'b100);
    do_tick();
    check("t3_mr", 8'(mora_result), 8'h1);
    hands(3'b000, 3'b000);
    Left_direct = 4'b0000;
    Right_direct = m_rnd;
    do_tick();
    check("t3_still_point", 8'(step), 8'h2);
    do_tick();
    check("t3_show_step", 8'(step), 8'h4);
    check("t3_flag", 8'(flag), 8'h0);
    check("t3_rs", 8'(Right_score), 8'h0);
    Right_direct = '0;
    do_tick();
    idle(2);

    // 4: left wins a second round -> game over
    hands(3'b100, 3'b010);
    do_tick();
    hands(3'b000, 3'b000);
    Right_direct = m_rnd;
    do_tick();
    check("t4_ls", 8'(Left_score), 8'h2);
    Right_direct = '0;
    do_tick();
    check("t4_flag_win", 8'(flag), 8'h2);
    check("t4_step_over", 8'(step), 8'h1);
    check("t4_done", 8'(round_done), 8'h1);
    idle(2);
    hands(3'b100, 3'b010);
    do_tick();
`ifdef ROUND_SEQUENCER_AUTO_RESTART_EN
    check("t4_restart_step", 8'(step), 8'h4);
    check("t4_restart_ls", 8'(Left_score), 8'h0);
    check("t4_restart_done", 8'(round_done), 8'h1);
`else
    check("t4_hold_step", 8'(step), 8'h1);
    check("t4_hold_flag", 8'(flag), 8'h2);
    check("t4_hold_ls", 8'(Left_score), 8'h2);
`endif
    hands(3'b000, 3'b000);
    pulse_reset();
    idle(2);

    // 5: asynchronous reset while pointing with Left_score=1
    hands(3'b100, 3'b010); do_tick();
    hands(3'b000, 3'b000); Right_direct = m_rnd; do_tick();
    Right_direct = '0; do_tick();
    hands(3'b100, 3'b010); do_tick();
    hands(3'b000, 3'b000);
    check("t5_pre_ls", 8'(Left_score), 8'h1);
    check("t5_pre_step", 8'(step), 8'h2);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_vals("t5_async");
    @(negedge CLK);
    RST = 1'b0;
    idle(2);

    // 6: multi-hot answer is a miss
    hands(3'b100, 3'b010); do_tick();
    hands(3'b000, 3'b000);
    Right_direct = 4'b1100;
    do_tick();
    check("t6_flag", 8'(flag), 8'h0);
    check("t6_step", 8'(step), 8'h4);
    check("t6_ls", 8'(Left_score), 8'h0);
    Right_direct = '0;
    do_tick();
    idle(3);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
